// File: rtl/ldpc_dvb_enc_obuf_reader_pkg.sv
// rtl/ldpc_dvb_enc_obuf_reader_pkg.sv - shared LDPC encoder types plus output buffer reader states
//
// Purpose: column word / column address types of the DVB-S2 LDPC encoder and
// the FSM state type of the output buffer reader.
package ldpc_dvb_enc_obuf_reader_pkg;

  localparam int cZ_W   = 360;  // Z bits per column word
  localparam int cCOL_W = 8;    // column address width

  typedef logic [cZ_W-1:0]   zdat_t;
  typedef logic [cCOL_W-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } obuf_state_t;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ldpc_dvb_enc_obuf_fifo.sv
// rtl/ldpc_dvb_enc_obuf_fifo.sv - show-ahead skid FIFO for the output buffer reader
//
// Purpose: synchronous FIFO whose head word is visible on odat without a pop.
// Ports:
//   iclk, ireset      clock, asynchronous active-high reset (empties the FIFO)
//   ipush, idat       write strobe and word
//   ipop              removes the head word (ignored when empty)
//   odat              head word (undefined content while empty)
//   ocount, oempty    current fill level and empty flag
module ldpc_dvb_enc_obuf_fifo
  import ldpc_dvb_enc_obuf_reader_pkg::*;
#(
  parameter int pDEPTH = 4,
  parameter int pDAT_W = cZ_W,
  parameter int pCNT_W = clog2_cnt(pDEPTH)
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              ipush,
  input  logic [pDAT_W-1:0] idat,
  input  logic              ipop,
  output logic [pDAT_W-1:0] odat,
  output logic [pCNT_W-1:0] ocount,
  output logic              oempty
);

  localparam int cPTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

  logic [pDAT_W-1:0] mem [pDEPTH];
  logic [cPTR_W-1:0] wptr;
  logic [cPTR_W-1:0] rptr;
  logic              do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [cPTR_W-1:0] ptr_inc(input logic [cPTR_W-1:0] p);
    return (p == cPTR_W'(pDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = ipop & !oempty;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      wptr   <= '0;
      rptr   <= '0;
      ocount <= '0;
    end else begin
      if (ipush)  wptr <= ptr_inc(wptr);
      if (do_pop) rptr <= ptr_inc(rptr);
      case ({ipush, do_pop})
        2'b10:   ocount <= ocount + 1'b1;
        2'b01:   ocount <= ocount - 1'b1;
        default: ocount <= ocount;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (ipush) mem[wptr] <= idat;
  end

  assign odat   = mem[rptr];
  assign oempty = (ocount == '0);

endmodule

// File: rtl/ldpc_dvb_enc_obuf_reader.sv
// rtl/ldpc_dvb_enc_obuf_reader.sv - drains the LDPC encoder output buffer as one codeword stream
//
// Purpose: on irfull, read columns 0..ncol-1 from the output buffer and stream
// them downstream; release the buffer (orempty) once the last beat is taken.
// Ports:
//   iclk, ireset, iclkena   clock, async active-high reset, clock enable
//   iused_col, irfull       columns in the codeword, buffer-full pulse
//   orread, oraddr, irdat   buffer read port (data pRAM_LAT enabled cycles later)
//   oval, osop, oeop, odat  output stream, iordy is downstream ready
//   orempty, obusy, oerr    buffer released pulse, frame active, sticky overrun
module ldpc_dvb_enc_obuf_reader
  import ldpc_dvb_enc_obuf_reader_pkg::*;
#(
  parameter int pDAT_W      = cZ_W,
  parameter int pCOL_W      = cCOL_W,
  parameter int pRAM_LAT    = 2,
  parameter int pFIFO_DEPTH = 4
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [pCOL_W-1:0] iused_col,
  input  logic              irfull,
  output logic              orread,
  output logic [pCOL_W-1:0] oraddr,
  input  logic [pDAT_W-1:0] irdat,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pDAT_W-1:0] odat,
  input  logic              iordy,
  output logic              orempty,
  output logic              obusy,
  output logic              oerr
);

  localparam int cCNT_W = clog2_cnt(pFIFO_DEPTH);

  obuf_state_t         state;
  obuf_state_t         state_nxt;
  logic [pCOL_W-1:0]   ncol;
  logic [pCOL_W-1:0]   rd_cnt;
  logic [pCOL_W-1:0]   beat_cnt;
  logic [pRAM_LAT-1:0] rd_vld_sr;
  logic                pend;
  logic                start;
  logic                rd;
  logic                last_rd;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                eop_acc;
  logic [cCNT_W-1:0]   fifo_count;
  logic [pDAT_W-1:0]   fifo_head;
  int                  credit;

  // Reads already in flight reserve a FIFO slot, so the FIFO can never overflow.
  assign credit = pFIFO_DEPTH - int'(fifo_count) - $countones(rd_vld_sr);

  assign fifo_push = iclkena & rd_vld_sr[pRAM_LAT-1];
  assign fifo_pop  = iclkena & oval & iordy;
  assign eop_acc   = fifo_pop & oeop;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       state <= IDLE;
    else if (iclkena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    rd        = 1'b0;
    last_rd   = 1'b0;
    case (state)
      IDLE: begin
        start = irfull | pend;
        if (start) state_nxt = READ;
      end
      READ: begin
        rd      = (credit > 0);
        last_rd = rd & (rd_cnt == ncol - 1'b1);
        if (last_rd) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (eop_acc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      ncol      <= '0;
      rd_cnt    <= '0;
      beat_cnt  <= '0;
      rd_vld_sr <= '0;
      pend      <= 1'b0;
      oerr      <= 1'b0;
      orempty   <= 1'b0;
    end else if (iclkena) begin
      orempty <= eop_acc;
      if (start) begin
        // A zero column count would never terminate; run it as one column.
        ncol     <= (iused_col == '0) ? pCOL_W'(1) : iused_col;
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end else begin
        if (rd)       rd_cnt   <= rd_cnt + 1'b1;
        if (fifo_pop) beat_cnt <= beat_cnt + 1'b1;
      end
      // In IDLE a set pending bit is consumed by the frame start; an irfull in
      // that same cycle becomes the new pending request.
      if (state == IDLE) begin
        pend <= pend & irfull;
      end else if (irfull) begin
        if (pend) oerr <= 1'b1;
        pend <= 1'b1;
      end
      rd_vld_sr[0] <= rd;
      for (int i = 1; i < pRAM_LAT; i++) rd_vld_sr[i] <= rd_vld_sr[i-1];
    end
  end

  ldpc_dvb_enc_obuf_fifo #(
    .pDEPTH (pFIFO_DEPTH),
    .pDAT_W (pDAT_W),
    .pCNT_W (cCNT_W)
  ) u_fifo (
    .iclk   (iclk),
    .ireset (ireset),
    .ipush  (fifo_push),
    .idat   (irdat),
    .ipop   (fifo_pop),
    .odat   (fifo_head),
    .ocount (fifo_count),
    .oempty (fifo_empty)
  );

  assign orread = rd;
  assign oraddr = rd_cnt;
  assign oval   = !fifo_empty;
  assign odat   = oval ? fifo_head : '0;
  assign osop   = oval & (beat_cnt == '0);
  assign oeop   = oval & (beat_cnt == ncol - 1'b1);
  assign obusy  = (state != IDLE);

endmodule

// File: tb/tb_ldpc_dvb_enc_obuf_reader.sv
// tb/tb_ldpc_dvb_enc_obuf_reader.sv - scoreboard bench for the LDPC output buffer reader
`timescale 1ns/1ps
module tb_ldpc_dvb_enc_obuf_reader;

  localparam int DW    = 360;
  localparam int CW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          iclk      = 1'b0;
  logic          ireset    = 1'b1;
  logic          iclkena   = 1'b1;
  logic          irfull    = 1'b0;
  logic          iordy     = 1'b1;
  logic [CW-1:0] iused_col = '0;
  logic          orread;
  logic [CW-1:0] oraddr;
  logic [DW-1:0] irdat;
  logic [DW-1:0] odat;
  logic          oval, osop, oeop, orempty, obusy, oerr;

  ldpc_dvb_enc_obuf_reader #(
    .pDAT_W(DW), .pCOL_W(CW), .pRAM_LAT(LAT), .pFIFO_DEPTH(DEPTH)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_col(iused_col),
    .irfull(irfull), .orread(orread), .oraddr(oraddr), .irdat(irdat),
    .oval(oval), .osop(osop), .oeop(oeop), .odat(odat), .iordy(iordy),
    .orempty(orempty), .obusy(obusy), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Buffer content: frame seed and column address, replicated to Z bits.
  function automatic logic [DW-1:0] mk(input int seed, input int addr);
    logic [23:0] w;
    w = {seed[15:0], addr[7:0]};
    return {15{w}};
  endfunction

  // Buffer RAM model: the writer refills the buffer after every release.
  logic [CW-1:0] ap_a [LAT];
  int            done_cnt = 0;
  int            seed_ofs = 0;
  logic          ena_q    = 1'b1;

  always @(posedge iclk) begin
    ena_q <= iclkena;
    if (iclkena) begin
      ap_a[0] <= oraddr;
      for (int i = 1; i < LAT; i++) ap_a[i] <= ap_a[i-1];
      if (orempty && !ireset) done_cnt <= done_cnt + 1;
    end
  end
  assign irdat = mk(done_cnt + seed_ofs, int'(ap_a[LAT-1]));

  // Random ready / clock-enable drivers.
  int rdy_pct  = 100;
  bit ena_rand = 1'b0;
  always @(negedge iclk) begin
    #1;
    iordy   = ($urandom_range(0, 99) < rdy_pct);
    iclkena = ena_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pop, hold-while-stalled, orempty after eop.
  int            beats      = 0;
  int            rempty_cnt = 0;
  logic          ovf        = 1'b0;
  logic          stall_q    = 1'b0;
  logic          eop_q      = 1'b0;
  logic          rempty_q   = 1'b0;
  logic [DW-1:0] dat_q;
  logic          sop_q, eoph_q;

  always @(negedge iclk) begin : mon
    beat_t e;
    #3;
    if (ireset) begin
      stall_q = 1'b0;
      eop_q   = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_val", oval, 1'b1);
        chk("hold_dat", odat, dat_q);
        chk("hold_sop", osop, sop_q);
        chk("hold_eop", oeop, eoph_q);
      end
      if (eop_q) begin
        chk("orempty_after_eop", orempty, 1'b1);
        chk("obusy_after_eop", obusy, 1'b0);
      end
      if (orempty && !rempty_q) rempty_cnt++;
      if (oval && iordy && iclkena) begin
        beats++;
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_dat", odat, e.dat);
          chk("beat_sop", osop, e.sop);
          chk("beat_eop", oeop, e.eop);
        end
      end
      if (dut.fifo_push && dut.fifo_count == DEPTH && !dut.fifo_pop) ovf = 1'b1;
      eop_q   = oval & iordy & iclkena & oeop;
      stall_q = oval & !(iordy & iclkena);
      dat_q   = odat;
      sop_q   = osop;
      eoph_q  = oeop;
    end
    rempty_q = orempty;
  end

  task automatic step();
    @(negedge iclk);
    #1;
  endtask

  int nfr = 0;

  // Pulse irfull on one enabled edge; queue the beats if the request is served.
  task automatic kick(input int n, input bit served);
    beat_t b;
    int    eff;
    int    guard;
    eff = (n == 0) ? 1 : n;
    if (served) begin
      for (int i = 0; i < eff; i++) begin
        b.dat = mk(nfr, i);
        b.sop = (i == 0);
        b.eop = (i == eff - 1);
        exp_q.push_back(b);
      end
      nfr++;
    end
    irfull = 1'b1;
    guard  = 0;
    do begin
      step();
      guard++;
    end while (!ena_q && guard < 100);
    irfull = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((obusy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_in_budget", n < budget, 1'b1);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_orread"},  orread,  1'b0);
    chk({tag, "_oraddr"},  oraddr,  '0);
    chk({tag, "_oval"},    oval,    1'b0);
    chk({tag, "_osop"},    osop,    1'b0);
    chk({tag, "_oeop"},    oeop,    1'b0);
    chk({tag, "_odat"},    odat,    '0);
    chk({tag, "_orempty"}, orempty, 1'b0);
    chk({tag, "_obusy"},   obusy,   1'b0);
    chk({tag, "_oerr"},    oerr,    1'b0);
  endtask

  initial begin
    int c0, b0, n;
    repeat (3) step();
    chk_all_zero("rst");
    ireset = 1'b0;
    step();

    // Basic frame: cycle-exact timing, ncol=3.
    iused_col = 3;
    kick(3, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      chk("basic_orread", orread, (k <= 3));
      if (k <= 3) chk("basic_oraddr", oraddr, k - 1);
      chk("basic_oval", oval, (k >= 4 && k <= 6));
      chk("basic_osop", osop, (k == 4));
      chk("basic_oeop", oeop, (k == 6));
      chk("basic_orempty", orempty, (k == 7));
      chk("basic_obusy", obusy, (k <= 6));
      step();
    end
    wait_idle(50);

    // Backpressure, 64 columns, ready 30% of cycles.
    rdy_pct   = 30;
    c0        = rempty_cnt;
    iused_col = 64;
    kick(64, 1'b1);
    wait_idle(3000);
    chk("bp_one_orempty", rempty_cnt - c0, 1);
    rdy_pct = 100;

    // Single column, and zero columns run as one.
    iused_col = 1;
    kick(1, 1'b1);
    wait_idle(50);
    iused_col = 0;
    kick(0, 1'b1);
    wait_idle(50);

    // Back-to-back via pending, then overrun.
    iused_col = 6;
    kick(6, 1'b1);
    step();
    step();
    kick(6, 1'b1);
    chk("b2b_oerr_clear", oerr, 1'b0);
    n = 0;
    while (!orempty && n < 100) begin
      step();
      n++;
    end
    chk("b2b_orempty_seen", orempty, 1'b1);
    repeat (4) step();
    chk("b2b_next_sop", oval & osop, 1'b1);
    kick(6, 1'b1);
    kick(6, 1'b0);
    chk("ovr_oerr_set", oerr, 1'b1);
    wait_idle(200);
    chk("ovr_oerr_sticky", oerr, 1'b1);

    // Reset at beat 10 of 64, then a clean frame.
    rdy_pct   = 60;
    iused_col = 64;
    b0        = beats;
    kick(64, 1'b1);
    n = 0;
    while (beats < b0 + 10 && n < 500) begin
      step();
      n++;
    end
    chk("rst_mid_reached", beats >= b0 + 10, 1'b1);
    ireset = 1'b1;
    step();
    chk_all_zero("rstmid");
    exp_q.delete();
    seed_ofs++;
    ireset = 1'b0;
    step();
    kick(64, 1'b1);
    wait_idle(3000);

    // Clock enable toggled at random with mild backpressure.
    ena_rand  = 1'b1;
    rdy_pct   = 70;
    iused_col = 20;
    c0        = rempty_cnt;
    kick(20, 1'b1);
    wait_idle(2000);
    chk("ena_one_orempty", rempty_cnt - c0, 1);
    ena_rand = 1'b0;
    rdy_pct  = 100;
    step();

    chk("no_fifo_overflow", ovf, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_dvb_enc_obuf_reader.md
# ldpc_dvb_enc_obuf_reader

Drain side of the DVB-S2 LDPC encoder output buffer. The encoder engine writes data columns and then parity columns into the buffer and signals "buffer full" with a one-cycle pulse. This block then reads columns 0 .. used_col-1 in order and streams them out as one codeword over a valid/ready interface. When the last beat is accepted it releases the buffer back to the writer.

## Interface
Parameters:
- pDAT_W, 360, column word width (Z bits), equals zdat_t width
- pCOL_W, 8, column address width, equals col_t width
- pRAM_LAT, 2, buffer read latency in cycles (1..3)
- pFIFO_DEPTH, 4, output skid FIFO depth, must be ≥ pRAM_LAT+1

Ports:
- iclk, in, 1, clock
- ireset, in, 1, reset: asynchronous, active-high
- iclkena, in, 1, clock enable; all state and the read pipeline hold while low
- iused_col, in, pCOL_W, total columns (data + parity); sampled at frame start
- irfull, in, 1, one-cycle pulse: buffer holds a complete codeword
- orread, out, 1, buffer read strobe
- oraddr, out, pCOL_W, buffer read address
- irdat, in, pDAT_W, buffer read data, valid pRAM_LAT enabled cycles after orread
- oval, out, 1, output beat valid
- osop, out, 1, first beat of codeword
- oeop, out, 1, last beat of codeword
- odat, out, pDAT_W, output column word
- iordy, in, 1, downstream ready
- orempty, out, 1, one-cycle pulse: buffer released
- obusy, out, 1, frame in progress
- oerr, out, 1, sticky: irfull overrun

## Operation
- Frame start:
  - In IDLE, an irfull pulse or a set pending bit starts a frame.
  - iused_col is latched into ncol.
  - The read counter is cleared and the state goes to READ.
- READ:
  - orread is asserted whenever credit > 0, where credit = pFIFO_DEPTH − fifo_count − inflight.
  - oraddr increments from 0 on each read.
  - After read ncol−1 is issued, the state goes to DRAIN.
- DRAIN: stay until the eop beat is accepted (oval & iordy & oeop), then go to IDLE.
- Read pipeline: a pRAM_LAT-stage valid shift register tracks in-flight reads and pushes irdat into the FIFO on return.
- Output:
  - oval = FIFO not empty. odat = FIFO head. A beat is popped on oval & iordy.
  - osop is set on beat index 0. oeop is set on beat index ncol−1.
- Pending and overrun:
  - irfull while obusy sets the pending bit.
  - irfull while pending is already set sets oerr. oerr is sticky until reset.
- ncol = 1 is legal: osop and oeop are on the same beat.
- ncol = 0 is illegal. It is treated as 1.

## Timing
- Reset values are all 0: orread, oraddr, oval, osop, oeop, odat, orempty, obusy, oerr, pending, and the FIFO is empty.
- The first orread is asserted in the cycle after irfull is sampled.
- Zero-backpressure latency from irfull to the first oval is pRAM_LAT+2 cycles. The stream is then gap-free at one beat per cycle.
- Backpressure:
  - iordy low must not lose or duplicate beats.
  - odat, osop and oeop stay stable while oval & !iordy.
- The FIFO must never overflow. A bench assertion checks this.
- orempty pulses in the cycle after the eop beat is accepted. obusy falls in the same cycle.
- If pending is set, the next frame starts in the cycle after orempty, so irfull → orempty is back-to-back.
- irfull in the same cycle as eop acceptance sets pending. It does not set oerr.
- Reset mid-frame aborts immediately: FIFO flushed, pipeline cleared, no orempty.
- With iclkena low, nothing advances, including the pipeline shift register.

## Structure
- The shared encoder types package supplies col_t, zdat_t and pDAT_W/pCOL_W derivation. This block adds an obuf_state_t enum (IDLE, READ, DRAIN) to that package.
- Sub-module: ldpc_dvb_enc_obuf_fifo, a synchronous show-ahead FIFO with push, pop, count and empty outputs, parameterised on depth and width.
- Read pipeline and FSM live in the top module.

## Test plan
- Basic frame:
  - Stimulus: ncol=3, pRAM_LAT=2, iordy=1, irfull at cycle 0.
  - Response: orread at cycles 1–3 with addresses 0,1,2. oval at cycles 4–6 with osop on the first beat and oeop on the third. orempty at cycle 7.
- Backpressure:
  - Stimulus: ncol=64, iordy random at 30%.
  - Response: 64 beats in address order, hold stable when stalled, no FIFO overflow, exactly one orempty.
- Single column:
  - Stimulus: ncol=1.
  - Response: one beat with osop=oeop=1. orempty one cycle after acceptance.
- Back-to-back:
  - Stimulus: second irfull mid-frame.
  - Response: second frame's osop follows orempty with no dropped frame and oerr=0.
  - Stimulus: third irfull while pending.
  - Response: oerr=1, stays 1.
- Reset mid-frame:
  - Stimulus: ireset at beat 10 of 64.
  - Response: all outputs 0 the next cycle. A new irfull produces a full clean frame starting at address 0.
- Clock enable:
  - Stimulus: iclkena toggled 50%.
  - Response: same beat sequence as with iclkena=1, stretched in time only.
